// File: rtl/hwag_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hwag_cmp
// Purpose  : Angle-compare output stage driving CH_NUM on/off-angle channels
//            from the hwag angle counter, with shadowed angle registers.
// Revision : 1.0
// ============================================================================
module hwag_cmp #(
    parameter int CH_NUM  = 4,
    parameter int ANGLE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANGLE_W-1:0] acnt,
    input  logic               acnt_stb,
    input  logic               hwag_sync,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [7:0]         bus_addr,
    input  logic [15:0]        bus_wdata,
    output logic [15:0]        bus_rdata,
    output logic [CH_NUM-1:0]  ch_out,
    output logic               irq
);

    localparam logic [7:0] c_ADDR_CR = 8'd0;
    localparam logic [7:0] c_ADDR_SR = 8'd1;

    logic               r_gen;
    logic               r_ie;
    logic [CH_NUM-1:0]  r_ch_en;
    logic               r_slf;
    logic               r_sync_d;
    logic               r_irq;
    logic [15:0]        r_rdata;
    logic [CH_NUM-1:0]  r_ch_out;
    logic [ANGLE_W-1:0] r_on_sh  [CH_NUM];
    logic [ANGLE_W-1:0] r_off_sh [CH_NUM];
    logic [ANGLE_W-1:0] r_on_a   [CH_NUM];
    logic [ANGLE_W-1:0] r_off_a  [CH_NUM];

    logic               w_wrap;
    logic               w_load;
    logic               w_cr_we;
    logic               w_gen_nx;
    logic [CH_NUM-1:0]  w_en_nx;
    logic               w_sync_fall;
    logic               w_slf_clr;
    logic               w_slf_nx;
    logic [CH_NUM-1:0]  w_on_we;
    logic [CH_NUM-1:0]  w_off_we;
    logic [CH_NUM-1:0]  w_on_hit;
    logic [CH_NUM-1:0]  w_off_hit;
    logic [15:0]        w_rd;

    always_comb begin
        w_wrap      = acnt_stb && (acnt == '0);
        w_load      = w_wrap || !r_gen || !hwag_sync;
        w_cr_we     = bus_we && (bus_addr == c_ADDR_CR);
        // Enables take effect with the write itself so forcing is one cycle.
        w_gen_nx    = w_cr_we ? bus_wdata[0] : r_gen;
        w_en_nx     = w_cr_we ? bus_wdata[8 +: CH_NUM] : r_ch_en;
        w_sync_fall = r_sync_d && !hwag_sync && r_gen;
        w_slf_clr   = bus_we && (bus_addr == c_ADDR_SR) && bus_wdata[0];
        w_slf_nx    = w_sync_fall || (r_slf && !w_slf_clr);
        w_on_we     = '0;
        w_off_we    = '0;
        w_on_hit    = '0;
        w_off_hit   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_on_we[i]   = bus_we && (bus_addr == 8'(2 + 2 * i));
            w_off_we[i]  = bus_we && (bus_addr == 8'(3 + 2 * i));
            // On the wrap strobe the shadow value is what gets loaded, so compare against it.
            w_on_hit[i]  = (acnt == (w_wrap ? r_on_sh[i]  : r_on_a[i]));
            w_off_hit[i] = (acnt == (w_wrap ? r_off_sh[i] : r_off_a[i]));
        end
    end

    always_comb begin
        w_rd = '0;
        if (bus_addr == c_ADDR_CR) begin
            w_rd[0]          = r_gen;
            w_rd[1]          = r_ie;
            w_rd[8 +: CH_NUM] = r_ch_en;
        end else if (bus_addr == c_ADDR_SR) begin
            w_rd[0] = r_slf;
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if (bus_addr == 8'(2 + 2 * i)) begin
                w_rd = 16'(r_on_sh[i]);
            end
            if (bus_addr == 8'(3 + 2 * i)) begin
                w_rd = 16'(r_off_sh[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen    <= 1'b0;
            r_ie     <= 1'b0;
            r_ch_en  <= '0;
            r_slf    <= 1'b0;
            r_sync_d <= 1'b0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_cr_we) begin
                r_gen   <= bus_wdata[0];
                r_ie    <= bus_wdata[1];
                r_ch_en <= bus_wdata[8 +: CH_NUM];
            end
            r_slf    <= w_slf_nx;
            r_sync_d <= hwag_sync;
            r_irq    <= r_slf && r_ie;
            if (bus_re) begin
                r_rdata <= w_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_on_sh[i]  <= '0;
                r_off_sh[i] <= '0;
                r_on_a[i]   <= '0;
                r_off_a[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (w_on_we[i]) begin
                    r_on_sh[i] <= bus_wdata[ANGLE_W-1:0];
                end
                if (w_off_we[i]) begin
                    r_off_sh[i] <= bus_wdata[ANGLE_W-1:0];
                end
                if (w_load) begin
                    r_on_a[i]  <= r_on_sh[i];
                    r_off_a[i] <= r_off_sh[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_out <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (!w_gen_nx || !w_en_nx[i] || !hwag_sync) begin
                    r_ch_out[i] <= 1'b0;
                end else if (acnt_stb) begin
                    if (w_off_hit[i]) begin
                        r_ch_out[i] <= 1'b0;
                    end else if (w_on_hit[i]) begin
                        r_ch_out[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus_rdata = r_rdata;
    assign ch_out    = r_ch_out;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_hwag_cmp.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_cmp
// Purpose  : Self-checking bench for hwag_cmp: directed sequences, register
//            vector table and randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_hwag_cmp;

    localparam int CH  = 4;
    localparam int TOP = 57;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] acnt;
    logic        acnt_stb;
    logic        hwag_sync;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic [CH-1:0] ch_out;
    logic        irq;

    hwag_cmp #(.CH_NUM(CH), .ANGLE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .acnt      (acnt),
        .acnt_stb  (acnt_stb),
        .hwag_sync (hwag_sync),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .ch_out    (ch_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: register file, angle snapshots and outputs.
    bit          m_gen, m_ie, m_slf, m_irq, m_sync_prev;
    bit [CH-1:0] m_en, m_out;
    logic [15:0] m_rd;
    int          m_on_sh[CH], m_off_sh[CH], m_on_a[CH], m_off_a[CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gen = 0; m_ie = 0; m_slf = 0; m_irq = 0; m_sync_prev = 0;
        m_en = '0; m_out = '0; m_rd = '0;
        for (int i = 0; i < CH; i++) begin
            m_on_sh[i] = 0; m_off_sh[i] = 0; m_on_a[i] = 0; m_off_a[i] = 0;
        end
    endtask

    function automatic logic [15:0] m_read(input logic [7:0] addr);
        int a = int'(addr);
        if (a == 0) return {4'b0, m_en, 6'b0, m_ie, m_gen};
        if (a == 1) return {15'b0, m_slf};
        if (a >= 2 && a < 2 + 2 * CH)
            return (a % 2 == 1) ? 16'(m_off_sh[(a - 2) / 2]) : 16'(m_on_sh[(a - 2) / 2]);
        return 16'h0000;
    endfunction

    // One clock: predict next state from current inputs, advance, compare.
    task automatic tick();
        bit          wrap, gen_n, ie_n, slf_n, irq_n, sync_n;
        bit [CH-1:0] en_n, out_n;
        logic [15:0] rd_n;
        int          on_sh_n[CH], off_sh_n[CH], on_a_n[CH], off_a_n[CH];
        int          a, on, off, ad;
        a    = int'(acnt);
        ad   = int'(bus_addr);
        wrap = acnt_stb && (a == 0);
        gen_n = m_gen; ie_n = m_ie; en_n = m_en;
        on_sh_n = m_on_sh; off_sh_n = m_off_sh; on_a_n = m_on_a; off_a_n = m_off_a;
        if (bus_we && ad == 0) begin
            gen_n = bus_wdata[0]; ie_n = bus_wdata[1]; en_n = bus_wdata[11:8];
        end
        if (bus_we && ad >= 2 && ad < 2 + 2 * CH) begin
            if (ad % 2 == 1) off_sh_n[(ad - 2) / 2] = int'(bus_wdata);
            else             on_sh_n[(ad - 2) / 2]  = int'(bus_wdata);
        end
        if (wrap || !m_gen || !hwag_sync) begin
            on_a_n = m_on_sh; off_a_n = m_off_sh;
        end
        for (int i = 0; i < CH; i++) begin
            on  = wrap ? m_on_sh[i]  : m_on_a[i];
            off = wrap ? m_off_sh[i] : m_off_a[i];
            out_n[i] = m_out[i];
            if (!(gen_n && en_n[i] && hwag_sync)) out_n[i] = 0;
            else if (acnt_stb) begin
                if (a == off)     out_n[i] = 0;
                else if (a == on) out_n[i] = 1;
            end
        end
        rd_n  = bus_re ? m_read(bus_addr) : m_rd;
        slf_n = m_slf;
        if (bus_we && ad == 1 && bus_wdata[0]) slf_n = 0;
        if (m_sync_prev && !hwag_sync && m_gen) slf_n = 1;
        irq_n  = m_slf && m_ie;
        sync_n = hwag_sync;
        @(posedge clk);
        #1;
        m_gen = gen_n; m_ie = ie_n; m_en = en_n; m_out = out_n; m_rd = rd_n;
        m_slf = slf_n; m_irq = irq_n; m_sync_prev = sync_n;
        m_on_sh = on_sh_n; m_off_sh = off_sh_n; m_on_a = on_a_n; m_off_a = off_a_n;
        chk("model_ch_out", 32'(ch_out), 32'(m_out));
        chk("model_irq", 32'(irq), 32'(m_irq));
        chk("model_rdata", 32'(bus_rdata), 32'(m_rd));
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus_we = 1; bus_addr = a; bus_wdata = d;
        tick();
        bus_we = 0;
    endtask

    task automatic rd(input logic [7:0] a);
        bus_re = 1; bus_addr = a;
        tick();
        bus_re = 0;
    endtask

    task automatic strobe(input int a);
        acnt = 16'(a); acnt_stb = 1;
        tick();
        acnt_stb = 0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        int   cur;

        rst = 1; acnt = 0; acnt_stb = 0; hwag_sync = 0;
        bus_we = 0; bus_re = 0; bus_addr = 0; bus_wdata = 0;
        model_reset();
        #2;
        chk("reset_ch_out", 32'(ch_out), 0);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_rdata", 32'(bus_rdata), 0);
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 0;

        // Basic window on channel 0
        wr(8'd0, 16'h0101); wr(8'd2, 16'd10); wr(8'd3, 16'd20);
        hwag_sync = 1; tick();
        for (int a = 0; a <= TOP; a++) begin
            strobe(a);
            chk("t1_ch0", 32'(ch_out[0]), 32'(a >= 10 && a < 20));
            chk("t1_others", 32'(ch_out[3:1]), 0);
        end

        // Window spanning the wrap on channel 1
        wr(8'd4, 16'd50); wr(8'd5, 16'd5); wr(8'd0, 16'h0301);
        for (int a = 0; a <= TOP; a++) begin
            strobe(a);
            chk("t2_rev1_ch1", 32'(ch_out[1]), 32'(a >= 50));
        end
        for (int a = 0; a <= TOP; a++) begin
            strobe(a);
            chk("t2_rev2_ch1", 32'(ch_out[1]), 32'(a >= 50 || a < 5));
        end

        // Mid-revolution reprogramming waits for the wrap
        for (int a = 0; a <= 30; a++) strobe(a);
        wr(8'd2, 16'd40); wr(8'd3, 16'd45);
        rd(8'd2);
        chk("t3_readback_on0", 32'(bus_rdata), 40);
        for (int a = 31; a <= TOP; a++) begin
            strobe(a);
            chk("t3_old_rev_ch0", 32'(ch_out[0]), 0);
        end
        for (int a = 0; a <= TOP; a++) begin
            strobe(a);
            chk("t3_new_rev_ch0", 32'(ch_out[0]), 32'(a >= 40 && a < 45));
        end

        // ON==OFF never asserts; disabling a channel forces it low
        wr(8'd6, 16'd15); wr(8'd7, 16'd15); wr(8'd0, 16'h0701);
        for (int a = 0; a <= TOP; a++) begin
            strobe(a);
            chk("t4_equal_ch2", 32'(ch_out[2]), 0);
        end
        wr(8'd7, 16'd25);
        for (int a = 0; a <= 20; a++) strobe(a);
        chk("t4_ch2_high", 32'(ch_out[2]), 1);
        wr(8'd0, 16'h0301);
        chk("t4_ch2_disabled", 32'(ch_out[2]), 0);

        // Sync loss, flag, interrupt and set-over-clear priority
        for (int a = 21; a <= 42; a++) strobe(a);
        wr(8'd0, 16'h0103);
        chk("t5_ch0_high", 32'(ch_out[0]), 1);
        hwag_sync = 0; tick();
        chk("t5_forced_low", 32'(ch_out), 0);
        chk("t5_irq_not_yet", 32'(irq), 0);
        rd(8'd1);
        chk("t5_slf_read", 32'(bus_rdata), 1);
        chk("t5_irq_set", 32'(irq), 1);
        wr(8'd1, 16'h0001);
        tick();
        chk("t5_irq_cleared", 32'(irq), 0);
        hwag_sync = 1; tick();
        bus_we = 1; bus_addr = 8'd1; bus_wdata = 16'h0001; hwag_sync = 0;
        tick();
        bus_we = 0;
        rd(8'd1);
        chk("t5_set_wins", 32'(bus_rdata), 1);
        wr(8'd1, 16'h0001); tick();

        // Register vector table
        vt[0] = '{8'd0,   16'h0F03, 16'h0F03};
        vt[1] = '{8'd0,   16'h0000, 16'h0000};
        vt[2] = '{8'd2,   16'h1234, 16'h1234};
        vt[3] = '{8'd9,   16'hBEEF, 16'hBEEF};
        vt[4] = '{8'd1,   16'h0000, 16'h0000};
        vt[5] = '{8'd10,  16'h5555, 16'h0000};
        vt[6] = '{8'hFF,  16'hAAAA, 16'h0000};
        vt[7] = '{8'd8,   16'h0039, 16'h0039};
        foreach (vt[k]) begin
            wr(vt[k].addr, vt[k].wdata);
            rd(vt[k].addr);
            chk($sformatf("vec%0d_rdata", k), 32'(bus_rdata), 32'(vt[k].exp));
        end
        tick(); tick();
        chk("rdata_held", 32'(bus_rdata), 16'h0039);
        wr(8'd2, 16'h0011);
        bus_we = 1; bus_re = 1; bus_addr = 8'd2; bus_wdata = 16'h0022;
        tick();
        bus_we = 0; bus_re = 0;
        chk("rw_same_old", 32'(bus_rdata), 16'h0011);
        rd(8'd2);
        chk("rw_same_new", 32'(bus_rdata), 16'h0022);

        // Randomized traffic checked against the model inside tick()
        hwag_sync = 1; cur = 0;
        wr(8'd0, 16'h0F03);
        for (int n = 0; n < 1500; n++) begin
            int r;
            acnt_stb = ($urandom_range(0, 3) != 0);
            if (acnt_stb) begin
                acnt = 16'(cur);
                cur  = (cur == TOP) ? 0 : cur + 1;
            end
            r = $urandom_range(0, 99);
            bus_we = 0; bus_re = 0;
            if (r < 8) begin
                bus_we   = 1;
                bus_addr = 8'($urandom_range(0, 11));
                if (bus_addr == 0)
                    bus_wdata = (16'($urandom) & 16'h0F03) | 16'($urandom_range(0, 7) != 0);
                else if (bus_addr == 1)
                    bus_wdata = 16'($urandom);
                else
                    bus_wdata = 16'($urandom_range(0, TOP));
            end else if (r < 25) begin
                bus_re   = 1;
                bus_addr = 8'($urandom_range(0, 11));
            end
            if (hwag_sync && $urandom_range(0, 199) == 0) hwag_sync = 0;
            else if (!hwag_sync && $urandom_range(0, 9) == 0) hwag_sync = 1;
            tick();
        end
        bus_we = 0; bus_re = 0; acnt_stb = 0;

        // Asynchronous reset mid-revolution
        wr(8'd0, 16'h0103); wr(8'd2, 16'd5); wr(8'd3, 16'd50);
        hwag_sync = 1; tick();
        hwag_sync = 0; tick();
        hwag_sync = 1; tick();
        for (int a = 0; a <= 20; a++) strobe(a);
        rd(8'd2);
        chk("t6_ch0_high", 32'(ch_out[0]), 1);
        chk("t6_irq_high", 32'(irq), 1);
        #2;
        rst = 1;
        #1;
        chk("t6_async_ch_out", 32'(ch_out), 0);
        chk("t6_async_irq", 32'(irq), 0);
        chk("t6_async_rdata", 32'(bus_rdata), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            rd(8'(k));
            chk($sformatf("t6_reg%0d_zero", k), 32'(bus_rdata), 0);
        end
        for (int a = 0; a <= TOP; a++) begin
            strobe(a);
            chk("t6_post_reset_out", 32'(ch_out), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwag_cmp.md
# hwag_cmp

Angle-compare output stage placed directly downstream of `hwag`. Consumes the angle counter and synchronisation status that `hwag` derives from the toothed-wheel VR signal. Drives `CH_NUM` ignition/injection outputs, each high between a programmable on-angle and off-angle. Configured over a simple synchronous register bus, with glitch-free shadow-register updates at each revolution wrap.

## Interface
- `CH_NUM`, 4: number of compare channels (1..8).
- `ANGLE_W`, 16: angle counter width.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `acnt` in ANGLE_W: current angle count from `hwag`. Counts 0..top, then wraps to 0.
- `acnt_stb` in 1: one-cycle strobe marking a new `acnt` value.
- `hwag_sync` in 1: high while `hwag` is synchronised to the wheel gap.
- `bus_we` in 1: register write strobe.
- `bus_re` in 1: register read strobe.
- `bus_addr` in 8: register address.
- `bus_wdata` in 16: write data.
- `bus_rdata` out 16: read data, registered.
- `ch_out` out CH_NUM: channel outputs.
- `irq` out 1: interrupt, level.

## Operation
Register map (word addresses):
- 0 CR:
  - bit0 global enable (GEN).
  - bit1 sync-loss interrupt enable (IE).
  - bits[8+i] channel i enable.
- 1 SR: bit0 sync-loss flag (SLF). Write 1 clears it; writing 0 has no effect.
- 2+2i ON_i: on-angle shadow of channel i, low ANGLE_W bits of `bus_wdata`.
- 3+2i OFF_i: off-angle shadow of channel i, same width rule.
- Unmapped addresses: writes ignored, reads return 0.
- Reads return the register or shadow value, never the active value.

Shadow and active angle registers:
- Each channel has active copies ON_A and OFF_A.
- Active copies load from shadow on every `acnt_stb` with `acnt`==0 (the wrap).
- Active copies also load when GEN is low or `hwag_sync` is low, so the first revolution after sync uses the current shadow values.
- Bus writes never modify active copies directly.

Per-channel compare:
- Evaluated only on `acnt_stb` cycles, and only while GEN, channel enable and `hwag_sync` are all high.
- `acnt`==OFF → output 0.
- Else `acnt`==ON → output 1.
- Else output holds.
- ON==OFF: OFF has priority, so the output stays 0.
- On the wrap strobe, the compare uses the freshly loaded values (shadow values feed the comparator in that cycle).
- The ON>OFF case spans the wrap naturally and needs no special handling.
- Equality-only compare: `hwag` delivers every angle value in sequence, so the block does not detect skipped values.

Forcing and sync loss:
- GEN low, channel enable low, or `hwag_sync` low forces that channel's output to 0 on the next clock.
- A falling edge of `hwag_sync` while GEN=1 sets SLF.
- If a set event and a clearing bus write occur in the same cycle, set wins.
- `irq` = SLF & IE, registered.

## Timing
- Reset values: `ch_out`=0, `irq`=0, `bus_rdata`=0, CR=0, SR=0, all shadow and active registers 0.
- Compare latency: a match on `acnt_stb` in cycle N appears on `ch_out` in cycle N+1.
- Write latency: a write in cycle N is visible to a read and in CR/SR in cycle N+1. Angle writes become active at the next wrap strobe (or immediately if unsynced).
- Read latency: `bus_re` with `bus_addr` in cycle N → `bus_rdata` valid in cycle N+1 and held until the next read.
- Simultaneous read and write to the same address returns the old value.
- Force latency: `hwag_sync` falling in cycle N → all `ch_out`=0 and SLF=1 in cycle N+1, `irq` high in cycle N+2 if IE=1.
- Asserting `rst` mid-revolution clears all state immediately. After release, outputs stay 0 until reprogrammed and a compare match occurs.
- `acnt_stb` may arrive back-to-back every clock, and every strobe is processed.

## Test plan
- Reset, then write CR=0x0101, ON_0=10, OFF_0=20, `hwag_sync`=1, sweep `acnt` 0..57 with strobes → `ch_out[0]` rises the cycle after acnt=10, falls the cycle after acnt=20. Other channels stay 0.
- Write ON_1=50, OFF_1=5, enable ch1, run two revolutions with top 57 → `ch_out[1]` high over acnt 50..57 and 0..4 across the wrap, low at 5.
- Mid-revolution at acnt=30, write ON_0=40, OFF_0=45 → no edge at 40 in the current revolution. After the wrap, output high at 40 and low at 45. Readback of ON_0 returns 40 immediately.
- ON_2=OFF_2=15 → `ch_out[2]` never asserts. Also write CR bit10=0 while `ch_out[2]` is high under other settings → output 0 next cycle.
- CR=0x0103 with ch0 high, drop `hwag_sync` → `ch_out`=0 the next cycle, SR reads 1, `irq`=1 one cycle later. Write SR=1 → `irq`=0. Repeat with set and clear in the same cycle → SLF stays 1.
- Assert `rst` while `ch_out[0]`=1 → `ch_out`, `irq`, `bus_rdata` and all registers read 0 without waiting for a clock edge.
